// File: rtl/blackbox_caller_pkg.sv
// Shared types and helpers for the pipelined blackbox caller.
// The S1 struct here is sized for the default build; the top re-declares it at its own W.
package blackbox_caller_pkg;

    typedef enum logic {
        MODE_PASS  = 1'b0,
        MODE_CHAIN = 1'b1
    } mode_e;

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int S1_W  = 32;
    localparam int S1_CW = chan_w(4);

    typedef struct packed {
        logic [S1_W:0]    sum;
        logic [S1_CW-1:0] chan;
        mode_e            mode;
        logic [S1_W:0]    val0;
    } s1_t;

endpackage

// File: rtl/blackbox_adder_reg.sv
// Registered W+1-bit adder stage: captures val1+val2 with carry when the stage advances.
module blackbox_adder_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         advance,
    input  logic         in_valid,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         out_valid,
    output logic [W:0]   sum
);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid)
                sum <= {1'b0, in1} + {1'b0, in2};
        end
    end

endmodule

// File: rtl/blackbox_caller_pipe.sv
// Two-stage caller: S1 registers the sum, S2 XORs with val0 or the channel's last result.
// One chain register per channel; valid/ready on both sides.
module blackbox_caller_pipe
    import blackbox_caller_pkg::*;
#(
    parameter int W   = 32,
    parameter int NCH = 4,
    parameter int CW  = chan_w(NCH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_chan,
    input  logic          in_mode,
    input  logic [W:0]    in_val0,
    input  logic [W-1:0]  in_val1,
    input  logic [W-1:0]  in_val2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_chan,
    output logic [W:0]    out_data,
    input  logic          clr
);

    typedef struct packed {
        logic [W:0]    sum;
        logic [CW-1:0] chan;
        mode_e         mode;
        logic [W:0]    val0;
    } s1_loc_t;

    s1_loc_t       s1;
    logic          s1_valid;
    logic [W:0]    s1_sum;
    logic [CW-1:0] s1_chan;
    mode_e         s1_mode;
    logic [W:0]    s1_val0;

    logic          s2_load;
    logic          s1_adv;
    logic          accept;
    logic [W:0]    chain_rd;
    logic [W:0]    res;
    logic [W:0]    chain [NCH];

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign s1_adv   = ~s1_valid | s2_load;
    assign in_ready = s1_adv & ~reset;
    assign accept   = in_valid & in_ready;

    blackbox_adder_reg #(.W(W)) u_add (
        .clock     (clock),
        .reset     (reset),
        .advance   (s1_adv),
        .in_valid  (accept),
        .in1       (in_val1),
        .in2       (in_val2),
        .out_valid (s1_valid),
        .sum       (s1_sum)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_chan <= '0;
            s1_mode <= MODE_PASS;
            s1_val0 <= '0;
        end else if (accept) begin
            s1_chan <= in_chan;
            s1_mode <= mode_e'(in_mode);
            s1_val0 <= in_val0;
        end
    end

    always_comb begin
        s1.sum  = s1_sum;
        s1.chan = s1_chan;
        s1.mode = s1_mode;
        s1.val0 = s1_val0;
    end

    // Scan rather than index so an illegal channel reads zero instead of going out of range.
    always_comb begin
        chain_rd = '0;
        for (int i = 0; i < NCH; i++)
            if (s1.chan == CW'(i))
                chain_rd = chain[i];
    end

    assign res = s1.sum ^ ((s1.mode == MODE_CHAIN) ? chain_rd : s1.val0);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_chan  <= s1.chan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A load on the same cycle as clr keeps its own channel's new result.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset)
                chain[i] <= '0;
            else if (s2_load && s1.chan == CW'(i))
                chain[i] <= res;
            else if (clr)
                chain[i] <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept)
            assert (int'(in_chan) < NCH);
    end

endmodule
